// File: rtl/hanoi_move_sequencer.sv
// Purpose: emits the optimal Tower-of-Hanoi move list (2^S-1 moves, SRC -> DST) as fr/to peg pairs.
// Latency: first move is presented 1 cycle after start; then up to 1 move per cycle.
// Backpressure: fr/to/mv_idx are held while mv_valid=1 and mv_ready=0; done pulses after the last handshake.
module hanoi_move_sequencer #(
    parameter int S   = 3,
    parameter int SRC = 0,
    parameter int DST = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         mv_ready,
    output logic         mv_valid,
    output logic [1:0]   fr,
    output logic [1:0]   to,
    output logic [S-1:0] mv_idx,
    output logic         busy,
    output logic         done
);

    if (SRC == DST) begin : g_bad_pegs
        $error("hanoi_move_sequencer: SRC and DST must name different pegs");
    end
    if (S < 1 || S > 8) begin : g_bad_size
        $error("hanoi_move_sequencer: S must be in 1..8");
    end
    if (SRC < 0 || SRC > 2 || DST < 0 || DST > 2) begin : g_bad_peg_range
        $error("hanoi_move_sequencer: SRC and DST must be in 0..2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0]   PEG_SRC = 2'(SRC);
    localparam logic [1:0]   PEG_DST = 2'(DST);
    localparam logic [1:0]   PEG_AUX = 2'(3 - SRC - DST);
    // Move arithmetic is one bit wider than k so (k | (k-1)) + 1 never overflows.
    localparam logic [S:0]   X_ONE   = (S+1)'(1);
    localparam logic [S:0]   X_THREE = (S+1)'(3);
    localparam logic [S-1:0] K_ONE   = S'(1);
    localparam logic [S-1:0] K_LAST  = '1;

    // Canonical peg (0=source, 1=aux, 2=destination) to physical peg number.
    function automatic logic [1:0] map_peg(input logic [1:0] c);
        logic [1:0] p;
        case (c)
            2'd0:    p = PEG_SRC;
            2'd1:    p = PEG_AUX;
            default: p = PEG_DST;
        endcase
        return p;
    endfunction

    // The closed form lands on canonical peg 2 only for odd S; even S swaps 1 and 2.
    function automatic logic [1:0] orient(input logic [1:0] c);
        logic [1:0] r;
        r = c;
        if ((S % 2) == 0) begin
            if (c == 2'd1)
                r = 2'd2;
            else if (c == 2'd2)
                r = 2'd1;
        end
        return r;
    endfunction

    // Physical {fr, to} for 1-based move number k.
    function automatic logic [3:0] move_of(input logic [S-1:0] k);
        logic [S:0] kx;
        logic [S:0] km1;
        logic [S:0] a;
        logic [S:0] b;
        logic [1:0] cf;
        logic [1:0] ct;
        kx  = {1'b0, k};
        km1 = kx - X_ONE;
        a   = kx & km1;
        b   = (kx | km1) + X_ONE;
        cf  = orient(2'(a % X_THREE));
        ct  = orient(2'(b % X_THREE));
        return {map_peg(cf), map_peg(ct)};
    endfunction

    state_t       state_q, state_d;
    logic [S-1:0] k_q, k_d;
    logic         mv_valid_q, mv_valid_d;
    logic [1:0]   fr_q, fr_d;
    logic [1:0]   to_q, to_d;
    logic [S-1:0] idx_q, idx_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [S-1:0] k_inc;
    logic [3:0]   mv_first;
    logic [3:0]   mv_next;

    // k_inc wraps only when k is the last move, where mv_next is not used.
    assign k_inc    = k_q + K_ONE;
    assign mv_first = move_of(K_ONE);
    assign mv_next  = move_of(k_inc);

    // Next-state and registered-output computation; abort wins over a same-cycle handshake.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        mv_valid_d = mv_valid_q;
        fr_d       = fr_q;
        to_d       = to_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    k_d        = K_ONE;
                    mv_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    fr_d       = mv_first[3:2];
                    to_d       = mv_first[1:0];
                    idx_d      = K_ONE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    k_d        = K_ONE;
                    mv_valid_d = 1'b0;
                    busy_d     = 1'b0;
                end else if (mv_valid_q && mv_ready) begin
                    if (k_q == K_LAST) begin
                        state_d    = ST_DONE;
                        mv_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        k_d   = k_inc;
                        fr_d  = mv_next[3:2];
                        to_d  = mv_next[1:0];
                        idx_d = k_inc;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                k_d     = K_ONE;
            end
            default: begin
                state_d    = ST_IDLE;
                k_d        = K_ONE;
                mv_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            k_q        <= K_ONE;
            mv_valid_q <= 1'b0;
            fr_q       <= 2'd0;
            to_q       <= 2'd0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            mv_valid_q <= mv_valid_d;
            fr_q       <= fr_d;
            to_q       <= to_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mv_valid = mv_valid_q;
    assign fr       = fr_q;
    assign to       = to_q;
    assign mv_idx   = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
